// File: rtl/rf_sequencer.sv
// rf_sequencer: command-driven micro-op sequencer that drives the 8-entry register file control word.
// Define RF_SEQ_SWAP_EN to implement SWAP (dst <-> src through scratch S4); otherwise opcode 110 is illegal.
module rf_sequencer #(
    parameter int DATA_W = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              CmdValid,
    output logic              CmdReady,
    input  logic [2:0]        CmdOp,
    input  logic [2:0]        CmdDst,
    input  logic [2:0]        CmdSrc,
    input  logic [DATA_W-1:0] CmdImm,
    input  logic [2:0]        ObsSel,
    input  logic [DATA_W-1:0] RfOutA,
    output logic [DATA_W-1:0] I,
    output logic [2:0]        FunSel,
    output logic [3:0]        RegSel,
    output logic [3:0]        ScrSel,
    output logic [2:0]        OutASel,
    output logic [2:0]        OutBSel,
    output logic              Done,
    output logic              Err
);
    localparam logic [2:0] FS_DEC  = 3'b000;
    localparam logic [2:0] FS_INC  = 3'b001;
    localparam logic [2:0] FS_LOAD = 3'b010;
    localparam logic [2:0] FS_CLR  = 3'b011;

    typedef enum logic [2:0] {
        IDLE,
        EXEC
`ifdef RF_SEQ_SWAP_EN
        , SW1, SW2, SW3
`endif
    } state_t;

    state_t            state_q;
    logic [7:0]        en_q;
    logic [2:0]        fun_q;
    logic [2:0]        outa_q;
    logic [2:0]        outb_q;
    logic [DATA_W-1:0] imm_q;
    logic              use_a_q;
    logic              done_q;
    logic              err_q;
`ifdef RF_SEQ_SWAP_EN
    logic [2:0]        dst_q;
    logic [2:0]        src_q;
`endif

    // Active-low enable vector {RegSel, ScrSel} with only register k enabled.
    function automatic logic [7:0] en_n(input logic [2:0] k);
        return ~(8'd1 << (3'd7 - k));
    endfunction

    // Sequencer FSM; every control-word field is registered so it is stable for the whole execute cycle.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            en_q    <= '1;
            fun_q   <= FS_DEC;
            outa_q  <= '0;
            outb_q  <= '0;
            imm_q   <= '0;
            use_a_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef RF_SEQ_SWAP_EN
            dst_q   <= '0;
            src_q   <= '0;
`endif
        end else begin
            outb_q  <= ObsSel;
            en_q    <= '1;
            fun_q   <= FS_DEC;
            outa_q  <= '0;
            imm_q   <= '0;
            use_a_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: if (CmdValid) begin
`ifdef RF_SEQ_SWAP_EN
                    dst_q <= CmdDst;
                    src_q <= CmdSrc;
                    if (CmdOp == 3'b110 && CmdDst != CmdSrc) begin
                        state_q <= SW1;
                        en_q    <= en_n(3'd7);
                        fun_q   <= FS_LOAD;
                        outa_q  <= CmdDst;
                        use_a_q <= 1'b1;
                    end else
`endif
                    begin
                        state_q <= EXEC;
                        done_q  <= 1'b1;
                        case (CmdOp)
                            3'b000: ;
                            3'b001: begin
                                en_q  <= en_n(CmdDst);
                                fun_q <= FS_LOAD;
                                imm_q <= CmdImm;
                            end
                            3'b010: begin
                                en_q    <= en_n(CmdDst);
                                fun_q   <= FS_LOAD;
                                outa_q  <= CmdSrc;
                                use_a_q <= 1'b1;
                            end
                            3'b011: begin
                                en_q  <= en_n(CmdDst);
                                fun_q <= FS_INC;
                            end
                            3'b100: begin
                                en_q  <= en_n(CmdDst);
                                fun_q <= FS_DEC;
                            end
                            3'b101: begin
                                en_q  <= en_n(CmdDst);
                                fun_q <= FS_CLR;
                            end
`ifdef RF_SEQ_SWAP_EN
                            3'b110: ;
`endif
                            default: begin
                                done_q <= 1'b0;
                                err_q  <= 1'b1;
                            end
                        endcase
                    end
                end
                EXEC: state_q <= IDLE;
`ifdef RF_SEQ_SWAP_EN
                SW1: begin
                    state_q <= SW2;
                    en_q    <= en_n(dst_q);
                    fun_q   <= FS_LOAD;
                    outa_q  <= src_q;
                    use_a_q <= 1'b1;
                end
                SW2: begin
                    state_q <= SW3;
                    en_q    <= en_n(src_q);
                    fun_q   <= FS_LOAD;
                    outa_q  <= 3'd7;
                    use_a_q <= 1'b1;
                    done_q  <= 1'b1;
                end
                SW3: state_q <= IDLE;
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign CmdReady = (state_q == IDLE);
    assign I        = use_a_q ? RfOutA : imm_q;
    assign FunSel   = fun_q;
    assign RegSel   = en_q[7:4];
    assign ScrSel   = en_q[3:0];
    assign OutASel  = outa_q;
    assign OutBSel  = outb_q;
    assign Done     = done_q;
    assign Err      = err_q;
endmodule
